// File: rtl/reci_nr_iter_if.sv
// Request/response bundle for the Newton-Raphson reciprocal unit.
// The caller holds the master side and the reciprocal engine holds the slave side.
interface reci_nr_iter_if #(
  parameter int FLT_WIDTH = 23,
  parameter int TAG_WIDTH = 4
);
  logic                 i_valid;
  logic                 i_ready;
  logic [FLT_WIDTH-1:0] i_x;
  logic [TAG_WIDTH-1:0] i_tag;
  logic                 o_valid;
  logic                 o_ready;
  logic [FLT_WIDTH-1:0] o_result;
  logic                 o_exact;
  logic [TAG_WIDTH-1:0] o_tag;

  modport master (
    output i_valid, i_x, i_tag, o_ready,
    input  i_ready, o_valid, o_result, o_exact, o_tag
  );

  modport slave (
    input  i_valid, i_x, i_tag, o_ready,
    output i_ready, o_valid, o_result, o_exact, o_tag
  );
endinterface

// File: rtl/reci_nr_iter.sv
// Multi-cycle Newton-Raphson reciprocal of X = 1.i_x, returning the fraction of 2/X.
// A table seed is refined NR_ITER times on a single shared multiplier.
module reci_nr_iter #(
  parameter int FLT_WIDTH  = 23,
  parameter int ADDR_WIDTH = 3,
  parameter int SEED_WIDTH = 8,
  parameter int GUARD      = 6,
  parameter int NR_ITER    = 3,
  parameter int TAG_WIDTH  = 4
) (
  input logic            clk,
  input logic            rst,
  reci_nr_iter_if.slave  bus
);
  localparam int F        = FLT_WIDTH;
  localparam int W        = FLT_WIDTH + GUARD;
  localparam int SEED_MAX = 2 ** (SEED_WIDTH + 1) - 1;
  localparam logic [2:0]   LAST_ITER = 3'(NR_ITER - 1);
  localparam logic [W+1:0] TWO       = {2'b10, {W{1'b0}}};

  typedef enum logic [2:0] {IDLE, SEED, MUL_T, MUL_Y, ROUND, DONE} state_e;
  typedef logic [2**ADDR_WIDTH-1:0][SEED_WIDTH:0] seed_tab_t;

  // Each entry is 2/X at the interval midpoint in Q1.SEED_WIDTH, i.e. twice the wanted 1/X seed.
  function automatic seed_tab_t buildSeedTable();
    seed_tab_t tab;
    longint    num;
    longint    den;
    longint    q;
    tab = '0;
    num = longint'(1) << (SEED_WIDTH + ADDR_WIDTH + 2);
    for (int a = 0; a < 2 ** ADDR_WIDTH; a++) begin
      den = longint'(2 ** (ADDR_WIDTH + 1) + 2 * a + 1);
      q   = num / den;
      if (q > longint'(SEED_MAX)) q = longint'(SEED_MAX);
      tab[a] = q[SEED_WIDTH:0];
    end
    return tab;
  endfunction

  localparam seed_tab_t SEED_TAB = buildSeedTable();

  state_e               state_q, state_d;
  logic [F-1:0]         x_q, x_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [W:0]           y_q, y_d;
  logic [W:0]           t_q, t_d;
  logic [2:0]           iter_q, iter_d;
  logic                 valid_q, valid_d;
  logic [F-1:0]         result_q, result_d;
  logic                 exact_q, exact_d;
  logic [TAG_WIDTH-1:0] oTag_q, oTag_d;

  logic [W:0]          xFull;
  logic [SEED_WIDTH:0] seedVal;
  logic [W:0]          yInit;
  logic [W+1:0]        twoMinusT;
  logic [W+1:0]        mulB;
  logic [2*W+2:0]      prod;
  logic [W:0]          prodW;
  logic [F:0]          rounded;
  logic [F-1:0]        roundRes;
  logic                unusedBits;

  assign xFull     = {1'b1, x_q, {GUARD{1'b0}}};
  assign seedVal   = SEED_TAB[x_q[F-1 -: ADDR_WIDTH]];
  assign yInit     = {1'b0, seedVal, {(W - SEED_WIDTH - 1){1'b0}}};
  assign twoMinusT = TWO - {1'b0, t_q};

  // The one multiplier always takes Y; the other operand is X for T, (2-T) for the Y update.
  assign mulB  = (state_q == MUL_Y) ? twoMinusT : {1'b0, xFull};
  assign prod  = {{(W+2){1'b0}}, y_q} * {{(W+1){1'b0}}, mulB};
  assign prodW = prod[2*W:W];

  // R = 2Y shifts Y left one place, so R's fraction is y_q[W-2:0] and the round bit is y_q[GUARD-2].
  assign rounded = {1'b0, y_q[W-2:GUARD-1]} + {{F{1'b0}}, y_q[GUARD-2]};

  always_comb begin
    roundRes = rounded[F-1:0];
    if (y_q[W] || rounded[F]) begin
      roundRes = '1;
    end else if (!y_q[W-1]) begin
      roundRes = '0;
    end
  end

  assign unusedBits = ^{prod[2*W+2:2*W+1], prod[W-1:0], y_q[GUARD-3:0]};

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    tag_d    = tag_q;
    y_d      = y_q;
    t_d      = t_q;
    iter_d   = iter_q;
    valid_d  = valid_q;
    result_d = result_q;
    exact_d  = exact_q;
    oTag_d   = oTag_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          x_d     = bus.i_x;
          tag_d   = bus.i_tag;
          state_d = SEED;
        end
      end
      SEED: begin
        y_d     = yInit;
        iter_d  = '0;
        state_d = MUL_T;
      end
      MUL_T: begin
        t_d     = prodW;
        state_d = MUL_Y;
      end
      MUL_Y: begin
        y_d     = prodW;
        iter_d  = iter_q + 3'd1;
        state_d = (iter_q == LAST_ITER) ? ROUND : MUL_T;
      end
      ROUND: begin
        result_d = (x_q == '0) ? '0 : roundRes;
        exact_d  = (x_q == '0);
        oTag_d   = tag_q;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.o_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      tag_q    <= '0;
      y_q      <= '0;
      t_q      <= '0;
      iter_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      exact_q  <= 1'b0;
      oTag_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      tag_q    <= tag_d;
      y_q      <= y_d;
      t_q      <= t_d;
      iter_q   <= iter_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      oTag_q   <= oTag_d;
    end
  end

  assign bus.i_ready  = (state_q == IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_exact  = exact_q;
  assign bus.o_tag    = oTag_q;
endmodule
